// File: rtl/div_ctrl_if.sv
// Signal bundle between div_ctrl and its neighbours: the EX stage, the hazard unit,
// HI/LO and the multi-cycle divider. slave = div_ctrl, master = its environment.
interface div_ctrl_if;
    logic        ex_div_valid;
    logic        ex_div_signed;
    logic [31:0] ex_opa;
    logic [31:0] ex_opb;
    logic        flush_i;
    logic        stall_down_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_busy_o;
    logic        div_timeout_o;

    // Handshake: div_start_o stays high, with stable operands, until a one-cycle
    // div_ready_i pulse or an annul; hilo_we_o is a one-cycle strobe that fires only
    // in a cycle where stall_down_i is low.
    modport slave (
        input  ex_div_valid, ex_div_signed, ex_opa, ex_opb, flush_i, stall_down_i,
        input  div_result_i, div_ready_i,
        output div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
        output stall_req_o, hilo_we_o, hi_o, lo_o, div_busy_o, div_timeout_o
    );

    modport master (
        output ex_div_valid, ex_div_signed, ex_opa, ex_opb, flush_i, stall_down_i,
        output div_result_i, div_ready_i,
        input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
        input  stall_req_o, hilo_we_o, hi_o, lo_o, div_busy_o, div_timeout_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer between EX and the multi-cycle divider: issues DIV/DIVU, stalls the pipe,
// buffers the result for HI/LO, and annuls/drains the divider on flush or watchdog expiry.
module div_ctrl #(
    parameter int TIMEOUT_CYCLES = 48,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic         clk,
    input  logic         rst,
    div_ctrl_if.slave    bus,
    output logic [1:0]   state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        DONE   = 2'd2,
        CANCEL = 2'd3
    } state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DR_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic              signed_q, signed_d;
    logic              start_q, start_d;
    logic              annul_q, annul_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            signed_q  <= 1'b0;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            wdog_q    <= '0;
            drain_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            signed_q  <= signed_d;
            start_q   <= start_d;
            annul_q   <= annul_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            wdog_q    <= wdog_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
        end
    end

    // annul defaults low so it is a single-cycle pulse wherever it is raised.
    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        signed_d  = signed_q;
        start_d   = start_q;
        annul_d   = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        wdog_d    = wdog_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                start_d = 1'b0;
                if (bus.ex_div_valid && !bus.flush_i) begin
                    opa_d    = bus.ex_opa;
                    opb_d    = bus.ex_opb;
                    signed_d = bus.ex_div_signed;
                    start_d  = 1'b1;
                    wdog_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                start_d = 1'b1;
                wdog_d  = wdog_q + WD_W'(1);
                if (bus.flush_i) begin
                    start_d = 1'b0;
                    annul_d = 1'b1;
                    drain_d = '0;
                    state_d = CANCEL;
                end else if (bus.div_ready_i) begin
                    hi_d    = bus.div_result_i[63:32];
                    lo_d    = bus.div_result_i[31:0];
                    start_d = 1'b0;
                    state_d = DONE;
                end else if (wdog_q == WD_LAST) begin
                    annul_d   = 1'b1;
                    start_d   = 1'b0;
                    timeout_d = 1'b1;
                    hi_d      = '0;
                    lo_d      = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                start_d = 1'b0;
                if (bus.flush_i || !bus.stall_down_i) begin
                    state_d = IDLE;
                end
            end
            CANCEL: begin
                start_d = 1'b0;
                if (drain_q == DR_LAST) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Releasing EX in DONE coincides with the HI/LO write strobe.
    always_comb begin
        bus.hilo_we_o   = (state_q == DONE) && !bus.flush_i && !bus.stall_down_i;
        bus.stall_req_o = bus.ex_div_valid && !bus.flush_i && (state_q != DONE);
        bus.div_busy_o  = (state_q != IDLE);
    end

    assign bus.div_start_o   = start_q;
    assign bus.div_annul_o   = annul_q;
    assign bus.div_signed_o  = signed_q;
    assign bus.div_opdata1_o = opa_q;
    assign bus.div_opdata2_o = opb_q;
    assign bus.hi_o          = hi_q;
    assign bus.lo_o          = lo_q;
    assign bus.div_timeout_o = timeout_q;
    assign state_o           = state_q;

endmodule
